// File: rtl/mau_swc_if.sv
// Bundle of execute-stage, data-memory and write-back signals around the MAU.
// Latency: none, wiring only.
// Backpressure: exu_mem_ready, dmem_gnt and dmem_rvalid travel through here untouched.
`timescale 1ns/1ps
interface mau_swc_if;
    logic        exu_mem_valid;
    logic        exu_mem_ready;
    logic        exu_mem_we;
    logic [2:0]  exu_mem_funct3;
    logic [31:0] exu_mem_addr;
    logic [31:0] exu_mem_wdata;
    logic [4:0]  exu_mem_rd;

    logic        dmem_req;
    logic        dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    logic [4:0]  mau_load_rd;
    logic [31:0] mau_load_data;
    logic        mau_load_en;
    logic        mau_busy;
    logic        mau_fault;

    // The MAU itself: takes ops and bus responses, drives bus requests and results.
    modport slave (
        input  exu_mem_valid, exu_mem_we, exu_mem_funct3, exu_mem_addr, exu_mem_wdata, exu_mem_rd,
        input  dmem_gnt, dmem_rvalid, dmem_rdata,
        output exu_mem_ready,
        output dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
        output mau_load_rd, mau_load_data, mau_load_en, mau_busy, mau_fault
    );

    // The surroundings: execute stage, data memory and write-back seen as one party.
    modport master (
        output exu_mem_valid, exu_mem_we, exu_mem_funct3, exu_mem_addr, exu_mem_wdata, exu_mem_rd,
        output dmem_gnt, dmem_rvalid, dmem_rdata,
        input  exu_mem_ready,
        input  dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
        input  mau_load_rd, mau_load_data, mau_load_en, mau_busy, mau_fault
    );
endinterface

// File: rtl/mau_swc.sv
// Memory access unit: runs one load/store on the dmem req/gnt/rvalid bus, extends load data for write-back.
// Latency: load result registered on the rvalid edge, held until a cycle_cnt==1 edge; faults one cycle after the cause.
// Backpressure: exu_mem_ready only in IDLE with no fault pending; dmem_req held until dmem_gnt.
`timescale 1ns/1ps
module mau_swc #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic       hclk,
    input  logic       hrst,
    input  logic [3:0] cycle_cnt,
    mau_swc_if.slave   bus
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_HOLD} state_t;

    state_t      state, state_nxt;
    logic        op_we;
    logic [2:0]  op_f3;
    logic [31:0] op_addr;
    logic [4:0]  op_rd;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [CW-1:0] tmo_cnt;
    logic        fault_q;
    logic        load_en_q;
    logic [4:0]  load_rd_q;
    logic [31:0] load_data_q;

    logic        ready_int;
    logic        accept;
    logic        in_f3_bad, in_misal, in_bad;
    logic        tmo_last, timeout;
    logic [3:0]  be_in;
    logic [31:0] wdata_in;
    logic [31:0] lane, load_ext;

    assign ready_int = (state == S_IDLE) && !fault_q;
    assign accept    = ready_int && bus.exu_mem_valid;
    assign tmo_last  = (tmo_cnt == CW'(TIMEOUT_CYC - 1));

    // Classify the incoming op and pre-compute its byte enables and replicated store data.
    always_comb begin
        in_f3_bad = 1'b0;
        in_misal  = 1'b0;
        be_in     = 4'b1111;
        wdata_in  = bus.exu_mem_wdata;
        if (bus.exu_mem_we)
            in_f3_bad = bus.exu_mem_funct3[2] || (bus.exu_mem_funct3[1:0] == 2'b11);
        else
            in_f3_bad = (bus.exu_mem_funct3 == 3'b011) || (bus.exu_mem_funct3[2:1] == 2'b11);
        case (bus.exu_mem_funct3[1:0])
            2'b00: begin
                be_in    = 4'b0001 << bus.exu_mem_addr[1:0];
                wdata_in = {4{bus.exu_mem_wdata[7:0]}};
            end
            2'b01: begin
                in_misal = bus.exu_mem_addr[0];
                be_in    = 4'b0011 << {bus.exu_mem_addr[1], 1'b0};
                wdata_in = {2{bus.exu_mem_wdata[15:0]}};
            end
            2'b10: in_misal = (bus.exu_mem_addr[1:0] != 2'b00);
            default: in_misal = 1'b0;
        endcase
        in_bad = in_f3_bad || in_misal;
    end

    // Abort when the budget runs out, unless this very edge completes the access.
    always_comb begin
        timeout = 1'b0;
        if (state == S_REQ)
            timeout = tmo_last && !(bus.dmem_gnt && op_we);
        else if (state == S_RESP)
            timeout = tmo_last && !bus.dmem_rvalid;
    end

    // Pick the addressed lane and extend it according to the load width/signedness.
    always_comb begin
        lane = bus.dmem_rdata >> {op_addr[1:0], 3'b000};
        case (op_f3)
            3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_ext = {24'd0, lane[7:0]};
            3'b101:  load_ext = {16'd0, lane[15:0]};
            default: load_ext = bus.dmem_rdata;
        endcase
    end

    // FSM state register; reset abandons any access in flight.
    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // FSM next-state: a rvalid during REQ (even with gnt) is never taken as load data.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept && !in_bad) state_nxt = S_REQ;
            S_REQ: begin
                if (bus.dmem_gnt && op_we) state_nxt = S_IDLE;
                else if (tmo_last)         state_nxt = S_IDLE;
                else if (bus.dmem_gnt)     state_nxt = S_RESP;
            end
            S_RESP: begin
                if (bus.dmem_rvalid)  state_nxt = (op_rd != 5'd0) ? S_HOLD : S_IDLE;
                else if (tmo_last)    state_nxt = S_IDLE;
            end
            S_HOLD: if (cycle_cnt == 4'd1) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: bus fields are driven only while requesting so they read 0 otherwise.
    always_comb begin
        bus.exu_mem_ready = ready_int;
        bus.mau_busy      = (state != S_IDLE);
        bus.dmem_req      = (state == S_REQ);
        bus.dmem_we       = (state == S_REQ) && op_we;
        bus.dmem_be       = (state == S_REQ) ? be_q : 4'd0;
        bus.dmem_addr     = (state == S_REQ) ? {op_addr[31:2], 2'b00} : 32'd0;
        bus.dmem_wdata    = (state == S_REQ) ? wdata_q : 32'd0;
        bus.mau_fault     = fault_q;
        bus.mau_load_en   = load_en_q;
        bus.mau_load_rd   = load_rd_q;
        bus.mau_load_data = load_data_q;
    end

    // Capture the accepted op; fields stay put for the whole access.
    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst) begin
            op_we   <= 1'b0;
            op_f3   <= 3'd0;
            op_addr <= 32'd0;
            op_rd   <= 5'd0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
        end else if (accept) begin
            op_we   <= bus.exu_mem_we;
            op_f3   <= bus.exu_mem_funct3;
            op_addr <= bus.exu_mem_addr;
            op_rd   <= bus.exu_mem_rd;
            be_q    <= be_in;
            wdata_q <= wdata_in;
        end
    end

    // Timeout counter: zeroed as an access starts, counts every REQ/RESP cycle.
    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst)
            tmo_cnt <= '0;
        else if (accept)
            tmo_cnt <= '0;
        else if ((state == S_REQ) || (state == S_RESP))
            tmo_cnt <= tmo_cnt + CW'(1);
    end

    // Single-cycle fault pulse; ready is held low during it so a second fault cannot follow back-to-back.
    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst) fault_q <= 1'b0;
        else      fault_q <= (accept && in_bad) || timeout;
    end

    // Write-back result: loaded on rvalid, held through HOLD, cleared on the cycle_cnt==1 edge.
    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst) begin
            load_en_q   <= 1'b0;
            load_rd_q   <= 5'd0;
            load_data_q <= 32'd0;
        end else if ((state == S_RESP) && bus.dmem_rvalid && (op_rd != 5'd0)) begin
            load_en_q   <= 1'b1;
            load_rd_q   <= op_rd;
            load_data_q <= load_ext;
        end else if ((state == S_HOLD) && (cycle_cnt == 4'd1)) begin
            load_en_q   <= 1'b0;
            load_rd_q   <= 5'd0;
            load_data_q <= 32'd0;
        end
    end
endmodule

// File: tb/tb_mau_swc.sv
// Scoreboard bench for mau_swc: stimulus pushes expectations, bus responder and result monitor check them.
// Latency: checks result one cycle after rvalid and release on the cycle_cnt==1 edge.
// Backpressure: randomised gnt/rvalid delays, withheld gnt for timeout, reset mid-access.
`timescale 1ns/1ps
module tb_mau_swc;
    localparam int TMO = 16;

    logic       hclk = 1'b0;
    logic       hrst = 1'b1;
    logic [3:0] cycle_cnt = 4'd0;
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         last_rv_cyc = -10;

    mau_swc_if bus();

    mau_swc #(.TIMEOUT_CYC(TMO)) dut (
        .hclk      (hclk),
        .hrst      (hrst),
        .cycle_cnt (cycle_cnt),
        .bus       (bus.slave)
    );

    typedef struct {
        bit          is_fault;
        logic [4:0]  rd;
        logic [31:0] data;
    } ev_t;

    typedef struct {
        bit          we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          gnt_dly;
        int          rv_dly;
        bit          no_gnt;
        bit          junk_rv;
    } bt_t;

    ev_t exp_q[$];
    bt_t bus_q[$];

    always #5 hclk = ~hclk;
    always @(posedge hclk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(posedge hclk);
            #1 cycle_cnt = 4'($urandom_range(0, 3));
        end
    end

    initial begin
        #700000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit is_legal(input bit we, input logic [2:0] f3, input logic [31:0] addr);
        bit ok;
        if (we) ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
        else    ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        return ok && ((addr % nbytes(f3)) == 0);
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] addr);
        int v;
        v = ((1 << nbytes(f3)) - 1) << (addr % 4);
        return 4'(v);
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] w);
        int n;
        n = nbytes(f3);
        if (n == 1) return (w & 32'hFF) * 32'h01010101;
        if (n == 2) return (w & 32'hFFFF) * 32'h00010001;
        return w;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata);
        longint unsigned mask, v;
        int n;
        n    = nbytes(f3);
        mask = (64'd1 << (8 * n)) - 1;
        v    = (64'(rdata) >> (8 * (addr % 4))) & mask;
        if (f3 < 3'd4 && n < 4 && ((v >> (8 * n - 1)) & 1) == 1) v = v | ~mask;
        return v[31:0];
    endfunction

    // ---------------- stimulus ----------------
    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (!(bus.exu_mem_ready === 1'b1 && bus.mau_busy === 1'b0) && n < 300) begin
            @(negedge hclk);
            n++;
        end
        if (n >= 300) begin
            checks++;
            failures++;
            $display("FAIL %s_idle_wait actual=busy required=idle", name);
        end
    endtask

    task automatic issue(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd, input logic [31:0] rdata,
                         input int gnt_dly, input int rv_dly, input bit no_gnt, input bit junk_rv);
        bt_t b;
        ev_t e;
        bit  legal;
        wait_idle("pre_issue");
        legal = is_legal(we, f3, addr);
        if (legal) begin
            b.we = we; b.be = exp_be(f3, addr); b.addr = {addr[31:2], 2'b00};
            b.wdata = exp_wdata(f3, wdata); b.rdata = rdata;
            b.gnt_dly = gnt_dly; b.rv_dly = rv_dly; b.no_gnt = no_gnt; b.junk_rv = junk_rv;
            bus_q.push_back(b);
        end
        e.is_fault = 1'b1; e.rd = 5'd0; e.data = 32'd0;
        if (!legal || no_gnt) exp_q.push_back(e);
        else if (!we && rd != 5'd0) begin
            e.is_fault = 1'b0; e.rd = rd; e.data = exp_load(f3, addr, rdata);
            exp_q.push_back(e);
        end
        bus.exu_mem_valid = 1'b1; bus.exu_mem_we = we; bus.exu_mem_funct3 = f3;
        bus.exu_mem_addr = addr; bus.exu_mem_wdata = wdata; bus.exu_mem_rd = rd;
        @(negedge hclk);
        bus.exu_mem_valid = 1'b0;
        if (!legal) begin
            chk("illegal_no_req", bus.dmem_req, 1'b0);
            @(negedge hclk);
            chk("illegal_ready_after", bus.exu_mem_ready, 1'b1);
        end
        wait_idle("post_issue");
    endtask

    // ---------------- data-memory responder ----------------
    initial begin
        bt_t cur;
        bit  in_req, gnt_prev;
        int  dly, reqcnt, rv_cnt;
        logic [31:0] rv_data;
        in_req = 0; gnt_prev = 0; dly = 0; reqcnt = 0; rv_cnt = 0; rv_data = 0;
        bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0; bus.dmem_rdata = 32'd0;
        forever begin
            @(negedge hclk);
            bus.dmem_gnt = 1'b0;
            bus.dmem_rvalid = 1'b0;
            bus.dmem_rdata = $urandom;
            if (rv_cnt > 0) begin
                rv_cnt--;
                if (rv_cnt == 0) begin
                    bus.dmem_rvalid = 1'b1;
                    bus.dmem_rdata = rv_data;
                    last_rv_cyc = cyc;
                end
            end
            if (gnt_prev) begin
                chk("req_drop_after_gnt", bus.dmem_req, 1'b0);
                gnt_prev = 0;
            end else begin
                if (in_req && bus.dmem_req !== 1'b1) begin
                    chk("timeout_expected", 32'(cur.no_gnt), 32'd1);
                    chk("timeout_req_cycles", 32'(reqcnt), 32'(TMO));
                    in_req = 0;
                end
                if (bus.dmem_req === 1'b1 && !in_req) begin
                    if (bus_q.size() == 0) begin
                        chk("unexpected_req", bus.dmem_req, 1'b0);
                    end else begin
                        cur = bus_q.pop_front();
                        in_req = 1; dly = cur.gnt_dly; reqcnt = 0;
                    end
                end
                if (in_req) begin
                    chk("dmem_addr", bus.dmem_addr, cur.addr);
                    chk("dmem_we", bus.dmem_we, cur.we);
                    chk("dmem_be", bus.dmem_be, cur.be);
                    if (cur.we) chk("dmem_wdata", bus.dmem_wdata, cur.wdata);
                    reqcnt++;
                    if (!cur.no_gnt) begin
                        if (dly == 0) begin
                            bus.dmem_gnt = 1'b1;
                            gnt_prev = 1;
                            in_req = 0;
                            if (!cur.we) begin
                                rv_cnt = cur.rv_dly;
                                rv_data = cur.rdata;
                                if (cur.junk_rv) bus.dmem_rvalid = 1'b1;
                            end
                        end else begin
                            dly--;
                        end
                    end
                end
            end
        end
    end

    // ---------------- write-back monitor ----------------
    initial begin
        bit          en_prev, f_prev;
        logic [3:0]  cc_prev;
        logic [4:0]  rd_h;
        logic [31:0] d_h;
        ev_t         ev;
        en_prev = 0; f_prev = 0; cc_prev = 0; rd_h = 0; d_h = 0;
        forever begin
            @(negedge hclk);
            if (hrst) begin
                en_prev = 0; f_prev = 0;
                continue;
            end
            if (bus.mau_fault === 1'b1) begin
                if (f_prev) chk("fault_width", 32'd2, 32'd1);
                chk("fault_with_load_en", bus.mau_load_en, 1'b0);
                if (exp_q.size() == 0) chk("unexpected_fault", bus.mau_fault, 1'b0);
                else begin
                    ev = exp_q.pop_front();
                    chk("fault_expected", 32'(ev.is_fault), 32'd1);
                end
            end
            if (en_prev) begin
                if (cc_prev == 4'd1) begin
                    chk("release_en", bus.mau_load_en, 1'b0);
                    chk("release_rd", bus.mau_load_rd, 5'd0);
                    chk("release_data", bus.mau_load_data, 32'd0);
                end else begin
                    chk("hold_en", bus.mau_load_en, 1'b1);
                    chk("hold_rd", bus.mau_load_rd, rd_h);
                    chk("hold_data", bus.mau_load_data, d_h);
                end
            end else if (bus.mau_load_en === 1'b1) begin
                chk("load_latency", 32'(cyc), 32'(last_rv_cyc + 1));
                if (exp_q.size() == 0) chk("unexpected_load", bus.mau_load_en, 1'b0);
                else begin
                    ev = exp_q.pop_front();
                    chk("load_not_fault", 32'(ev.is_fault), 32'd0);
                    chk("load_rd", bus.mau_load_rd, ev.rd);
                    chk("load_data", bus.mau_load_data, ev.data);
                    rd_h = ev.rd;
                    d_h = ev.data;
                end
            end
            en_prev = (bus.mau_load_en === 1'b1);
            f_prev  = (bus.mau_fault === 1'b1);
            cc_prev = cycle_cnt;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        bt_t b;
        bus.exu_mem_valid = 1'b0; bus.exu_mem_we = 1'b0; bus.exu_mem_funct3 = 3'd0;
        bus.exu_mem_addr = 32'd0; bus.exu_mem_wdata = 32'd0; bus.exu_mem_rd = 5'd0;
        repeat (2) @(negedge hclk);
        chk("rst_ready", bus.exu_mem_ready, 1'b1);
        chk("rst_req", bus.dmem_req, 1'b0);
        chk("rst_busy", bus.mau_busy, 1'b0);
        chk("rst_fault", bus.mau_fault, 1'b0);
        chk("rst_load_en", bus.mau_load_en, 1'b0);
        chk("rst_addr", bus.dmem_addr, 32'd0);
        hrst = 1'b0;
        @(negedge hclk);

        issue(0, 3'b010, 32'h100, 32'd0, 5'd5, 32'hDEADBEEF, 1, 2, 0, 0);
        issue(0, 3'b000, 32'h103, 32'd0, 5'd7, 32'h80FFFFFF, 0, 1, 0, 0);
        issue(0, 3'b100, 32'h103, 32'd0, 5'd8, 32'h80FFFFFF, 2, 1, 0, 0);
        issue(0, 3'b101, 32'h102, 32'd0, 5'd9, 32'hBEEF1234, 0, 3, 0, 0);
        issue(1, 3'b000, 32'h201, 32'h000000A5, 5'd0, 32'd0, 1, 1, 0, 0);
        issue(0, 3'b010, 32'h102, 32'd0, 5'd3, 32'd0, 0, 1, 0, 0);
        issue(0, 3'b010, 32'h104, 32'd0, 5'd3, 32'h12345678, 0, 1, 1, 0);
        issue(0, 3'b001, 32'h106, 32'd0, 5'd11, 32'h8001CAFE, 0, 2, 0, 1);
        issue(0, 3'b010, 32'h108, 32'd0, 5'd0, 32'h55555555, 0, 1, 0, 0);
        issue(1, 3'b011, 32'h10C, 32'd0, 5'd0, 32'd0, 0, 1, 0, 0);

        // Reset while the load waits for rvalid; the late rvalid must be ignored.
        wait_idle("rst_test");
        b.we = 0; b.be = 4'hF; b.addr = 32'h300; b.wdata = 0; b.rdata = 32'hAAAA5555;
        b.gnt_dly = 0; b.rv_dly = 5; b.no_gnt = 0; b.junk_rv = 0;
        bus_q.push_back(b);
        bus.exu_mem_valid = 1'b1; bus.exu_mem_we = 1'b0; bus.exu_mem_funct3 = 3'b010;
        bus.exu_mem_addr = 32'h300; bus.exu_mem_rd = 5'd4;
        @(negedge hclk);
        bus.exu_mem_valid = 1'b0;
        @(negedge hclk);
        chk("resp_busy", bus.mau_busy, 1'b1);
        chk("resp_no_req", bus.dmem_req, 1'b0);
        #2 hrst = 1'b1;
        #1;
        chk("arst_busy", bus.mau_busy, 1'b0);
        chk("arst_ready", bus.exu_mem_ready, 1'b1);
        chk("arst_load_en", bus.mau_load_en, 1'b0);
        chk("arst_fault", bus.mau_fault, 1'b0);
        @(negedge hclk);
        hrst = 1'b0;
        repeat (8) @(negedge hclk);
        issue(0, 3'b010, 32'h300, 32'd0, 5'd4, 32'h0BADF00D, 1, 1, 0, 0);

        for (int i = 0; i < 150; i++) begin
            bit          we;
            logic [2:0]  f3;
            logic [31:0] addr;
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << f3[1:0]) - 32'd1);
            issue(we, f3, addr, $urandom, 5'($urandom_range(0, 31)), $urandom,
                  $urandom_range(0, 3), $urandom_range(1, 3), 0, ($urandom_range(0, 3) == 0));
        end

        repeat (10) @(negedge hclk);
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        chk("bus_q_drained", 32'(bus_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
